// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. A single h/v counter pair
//   drives hsync, vsync, data-enable, raw pixel coordinates, line/frame
//   strobes and an optional frame counter. Timing advances only on cycles
//   where pix_ce is high; every output comes from one register stage.
//
//   Optional feature macro: VGA_TIMING_FRAME_CNT_EN
//     defined   - frame_cnt counts frame_start strobes (modulo 2^FRAME_W)
//     undefined - frame_cnt is tied to 0
//
// Ports
//   sys_clk     in   system clock, rising edge
//   sys_rst     in   synchronous active-high reset, priority over pix_ce
//   pix_ce      in   pixel clock-enable
//   hsync_out   out  horizontal sync, active level HS_POL
//   vsync_out   out  vertical sync, active level VS_POL
//   de_out      out  high inside the active area
//   x_out       out  raw horizontal count
//   y_out       out  raw vertical count
//   line_start  out  one-sys_clk strobe at h=0
//   frame_start out  one-sys_clk strobe at h=0, v=0
//   frame_cnt   out  frames started, modulo 2^FRAME_W
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 56,
    parameter int unsigned H_SYNC   = 120,
    parameter int unsigned H_BP     = 64,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 37,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 23,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned CW       = 11,
    parameter int unsigned FRAME_W  = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               pix_ce,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               de_out,
    output logic [CW-1:0]      x_out,
    output logic [CW-1:0]      y_out,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Inclusive bounds so no constant ever needs to hold H_TOTAL itself.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic          de_d, hsync_d, vsync_d, line_start_d, frame_start_d;

    always_comb begin
        h_cnt_d       = h_cnt_q + CW'(1);
        v_cnt_d       = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
        end

        // Output values decoded from the pre-increment counts.
        de_d          = (h_cnt_q <= H_ACT_LAST) && (v_cnt_q <= V_ACT_LAST);
        hsync_d       = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ? HS_POL : ~HS_POL;
        vsync_d       = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ? VS_POL : ~VS_POL;
        line_start_d  = pix_ce && (h_cnt_q == '0);
        frame_start_d = pix_ce && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            de_out      <= 1'b0;
            hsync_out   <= ~HS_POL;
            vsync_out   <= ~VS_POL;
            x_out       <= '0;
            y_out       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Strobes reload every cycle so they can never stretch.
            line_start  <= line_start_d;
            frame_start <= frame_start_d;
            if (pix_ce) begin
                h_cnt_q   <= h_cnt_d;
                v_cnt_q   <= v_cnt_d;
                de_out    <= de_d;
                hsync_out <= hsync_d;
                vsync_out <= vsync_d;
                x_out     <= h_cnt_q;
                y_out     <= v_cnt_q;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_cnt_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_cnt_q <= '0;
        end else if (frame_start_d) begin
            frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small 8x6 raster
// (H 4/1/2/1, V 3/1/1/1). dut_p uses active-high syncs, dut_n active-low.
module tb_vga_timing_gen;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       pix_ce;

    logic       hs_p, vs_p, de_p, ls_p, fs_p;
    logic [3:0] x_p, y_p;
    logic [1:0] fc_p;
    logic       hs_n, vs_n, de_n, ls_n, fs_n;
    logic [3:0] x_n, y_n;
    logic [1:0] fc_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FRAME_W(2)
    ) dut_p (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pix_ce(pix_ce),
        .hsync_out(hs_p), .vsync_out(vs_p), .de_out(de_p),
        .x_out(x_p), .y_out(y_p), .line_start(ls_p), .frame_start(fs_p),
        .frame_cnt(fc_p)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .FRAME_W(2)
    ) dut_n (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pix_ce(pix_ce),
        .hsync_out(hs_n), .vsync_out(vs_n), .de_out(de_n),
        .x_out(x_n), .y_out(y_n), .line_start(ls_n), .frame_start(fs_n),
        .frame_cnt(fc_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge that loaded them.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_de"}, 32'(de_p), 0);
        check_eq({tag, "_x"}, 32'(x_p), 0);
        check_eq({tag, "_y"}, 32'(y_p), 0);
        check_eq({tag, "_hs_p"}, 32'(hs_p), 0);
        check_eq({tag, "_vs_p"}, 32'(vs_p), 0);
        check_eq({tag, "_hs_n"}, 32'(hs_n), 1);
        check_eq({tag, "_vs_n"}, 32'(vs_n), 1);
        check_eq({tag, "_ls"}, 32'(ls_p), 0);
        check_eq({tag, "_fs"}, 32'(fs_p), 0);
        check_eq({tag, "_fc"}, 32'(fc_p), 0);
    endtask

    // Runs from a freshly released reset; pix_ce high every 'period' cycles.
    task automatic run_seq(input int ticks, input int period);
        int  p = -1;
        int  ex, ey, efc;
        int  window = 48 * period;
        int  cnt_de = 0, cnt_hs = 0, cnt_vs = 0, cnt_ls = 0, cnt_fs = 0;
        int  last_fs = -1;
        bit  ce;
        bit  e_de, e_hs, e_vs;
        for (int i = 0; i < ticks; i++) begin
            ce     = (i % period) == 0;
            pix_ce = ce;
            tick();
            if (ce) p++;
            ex   = p % 8;
            ey   = (p / 8) % 6;
            e_de = (ex < 4) && (ey < 3);
            e_hs = (ex == 5) || (ex == 6);
            e_vs = (ey == 4);
`ifdef VGA_TIMING_FRAME_CNT_EN
            efc  = (p / 48 + 1) % 4;
`else
            efc  = 0;
`endif
            check_eq("x", 32'(x_p), 32'(ex));
            check_eq("y", 32'(y_p), 32'(ey));
            check_eq("de", 32'(de_p), 32'(e_de));
            check_eq("hs_p", 32'(hs_p), 32'(e_hs));
            check_eq("vs_p", 32'(vs_p), 32'(e_vs));
            check_eq("hs_n", 32'(hs_n), 32'(!e_hs));
            check_eq("vs_n", 32'(vs_n), 32'(!e_vs));
            check_eq("line_start", 32'(ls_p), 32'(ce && ex == 0));
            check_eq("frame_start", 32'(fs_p), 32'(ce && ex == 0 && ey == 0));
            check_eq("frame_cnt", 32'(fc_p), 32'(efc));
            if (i < window) begin
                cnt_de += int'(de_p);
                cnt_hs += int'(hs_p);
                cnt_vs += int'(vs_p);
                cnt_ls += int'(ls_p);
                cnt_fs += int'(fs_p);
            end
            if (fs_p) begin
                if (last_fs >= 0) check_eq("fs_period", 32'(i - last_fs), 32'(window));
                last_fs = i;
            end
        end
        pix_ce = 1'b0;
        if (ticks >= window) begin
            check_eq("de_cycles", 32'(cnt_de), 32'(12 * period));
            check_eq("hs_cycles", 32'(cnt_hs), 32'(12 * period));
            check_eq("vs_cycles", 32'(cnt_vs), 32'(8 * period));
            check_eq("ls_cycles", 32'(cnt_ls), 6);
            check_eq("fs_cycles", 32'(cnt_fs), 1);
        end
    endtask

    initial begin
        // Reset with pix_ce high: reset must win.
        sys_rst = 1'b1;
        pix_ce  = 1'b1;
        repeat (3) tick();
        check_reset("rst0");

        // Five frames at one pixel per clock; frame_cnt 1,2,3,0,1.
        sys_rst = 1'b0;
        run_seq(240, 1);

        // pix_ce every third cycle.
        sys_rst = 1'b1;
        repeat (2) tick();
        check_reset("rst1");
        sys_rst = 1'b0;
        run_seq(288, 3);

        // Reset mid-frame while the counters sit at h=3, v=2.
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        run_seq(19, 1);
        check_eq("pre_rst_x", 32'(x_p), 2);
        check_eq("pre_rst_y", 32'(y_p), 2);
        sys_rst = 1'b1;
        pix_ce  = 1'b1;
        tick();
        check_reset("rst_mid");
        sys_rst = 1'b0;
        tick();
        check_eq("restart_x", 32'(x_p), 0);
        check_eq("restart_y", 32'(y_p), 0);
        check_eq("restart_ls", 32'(ls_p), 1);
        check_eq("restart_fs", 32'(fs_p), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check_eq("restart_fc", 32'(fc_p), 1);
`else
        check_eq("restart_fc", 32'(fc_p), 0);
`endif
        // Held pix_ce: strobe drops after one cycle.
        tick();
        check_eq("restart_ls_drop", 32'(ls_p), 0);
        check_eq("restart_fs_drop", 32'(fs_p), 0);
        check_eq("restart_x1", 32'(x_p), 1);
        pix_ce = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: a single h/v counter pair replaces the separate hsync/vsync blocks. It produces hsync, vsync, data-enable, pixel coordinates, line/frame strobes and an optional frame counter, all from one system clock gated by a pixel clock-enable. It sits between the clock source and the pixel colour/render logic, which consumes `x`, `y` and `de`. Defaults give SVGA 800x600@72 (50 MHz pixel rate).

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 56, horizontal front porch (pixels)
- `H_SYNC`, 120, hsync pulse width (pixels)
- `H_BP`, 64, horizontal back porch (pixels)
- `V_ACTIVE`, 600, visible lines per frame
- `V_FP`, 37, vertical front porch (lines)
- `V_SYNC`, 6, vsync pulse width (lines)
- `V_BP`, 23, vertical back porch (lines)
- `HS_POL`, 1, hsync active level (1 = active-high)
- `VS_POL`, 1, vsync active level
- `CW`, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- `FRAME_W`, 8, frame counter width
- `sys_clk` in 1 — system clock, rising edge
- `sys_rst` in 1 — synchronous, active-high reset
- `pix_ce` in 1 — pixel clock-enable; timing advances only on cycles where it is high
- `hsync_out` out 1 — horizontal sync, polarity per HS_POL
- `vsync_out` out 1 — vertical sync, polarity per VS_POL
- `de_out` out 1 — high inside the active area
- `x_out` out CW — raw horizontal count
- `y_out` out CW — raw vertical count
- `line_start` out 1 — one-sys_clk strobe at h=0
- `frame_start` out 1 — one-sys_clk strobe at h=0, v=0
- `frame_cnt` out FRAME_W — frames started, modulo 2^FRAME_W

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL is defined the same way from the V_* parameters.
- Counters: internal `h_cnt` runs 0..H_TOTAL-1 and `v_cnt` runs 0..V_TOTAL-1, both exact with no extra count.
- Counter advance, on each `pix_ce` cycle:
  - `h_cnt` increments; at H_TOTAL-1 it wraps to 0.
  - `v_cnt` increments only on the `h_cnt` wrap; it wraps to 0 at V_TOTAL-1.
- Output load: on a `pix_ce` cycle, the outputs load from the pre-increment `h_cnt`/`v_cnt`:
  - `de` = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync is active iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC; otherwise it is at the inactive level.
  - vsync is active iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC. It depends only on v, not h.
  - `x_out` = h and `y_out` = v, in all regions including blanking.
  - `line_start` = (h==0).
  - `frame_start` = (h==0 && v==0).
- Strobe clearing: `line_start` and `frame_start` are cleared on every cycle not loading them as 1. They never stay high for more than one sys_clk, even when `pix_ce` is held high.
- Hold: with `pix_ce` low, counters and all level outputs hold.
- Reset: `sys_rst` has priority over `pix_ce`. Reset values:
  - counters = 0, `de`=0, `x_out`=0, `y_out`=0
  - hsync = ~HS_POL, vsync = ~VS_POL
  - strobes = 0, `frame_cnt` = 0
- Reset mid-frame: the raster restarts. The first `pix_ce` cycle after reset emits h=0, v=0 with both strobes.

## Timing
- Latency: outputs lag the counter by exactly one `pix_ce` cycle. All outputs come from one registered stage and are mutually aligned.
- No combinational paths from input to output.
- `pix_ce` tied high gives one pixel per sys_clk.
- `frame_cnt` updates in the same cycle `frame_start` is asserted. It wraps from 2^FRAME_W-1 to 0.
- Boundary case: h=H_TOTAL-1 and v=V_TOTAL-1 on the same `pix_ce` cycle wraps both counters. The next `pix_ce` emits the frame origin.

## Configuration
- Macro: `VGA_TIMING_FRAME_CNT_EN`.
- Defined: `frame_cnt` is a FRAME_W-bit register, incremented on each `frame_start` and cleared by reset. The first frame after reset reads 1.
- Undefined: `frame_cnt` is tied to 0 and no counter register is built. All other behaviour is identical.

## Test plan
- Small raster (H 4/1/2/1, V 3/1/1/1, `pix_ce`=1, CW=4), one full frame:
  - stimulus: run one frame of 48 cycles.
  - `de` high for 12 cycles total.
  - hsync (active-high) high at x=5,6 on every line.
  - vsync high for all 8 cycles with y=4.
  - `frame_start` repeats every 48 cycles.
- `pix_ce` high every 3rd cycle: each output state lasts 3 sys_clk, except strobes, which are exactly 1 sys_clk wide. `frame_start` period = 144 cycles.
- HS_POL=0, VS_POL=0, reset: hsync and vsync = 1 during reset. Both go low only in their sync windows.
- Assert `sys_rst` at x=3, y=2 together with `pix_ce`=1: the reset wins. The next output after release is x=0, y=0 with `line_start`=`frame_start`=1.
- Default SVGA parameters, `VGA_TIMING_FRAME_CNT_EN` defined, FRAME_W=2:
  - `frame_start` period = 1040×666 = 692640 cycles.
  - `frame_cnt` sequence 1,2,3,0,1.
  - With the macro undefined, `frame_cnt` stays 0.
- Frame-end wrap, small raster: output x=7, y=5 is followed by x=0, y=0 on the next `pix_ce`. Neither y=6 nor x=8 ever appears.
